// File: rtl/pulse_out_pio.sv
// rtl/pulse_out_pio.sv - Avalon-MM output PIO with atomic set/clear and timed per-bit pulses
//
// Drives WIDTH output pins from a data register. Each bit can also be given
// a one-shot pulse of len clk cycles, which is XORed onto the data value.
// When a pulse ends, that bit's done flag is set. irq is the OR of the
// done flags that are enabled in irq_mask.
//
// Register map (word address):
//   0 DATA  1 SET  2 CLR  3 PULSE/active  4 LEN  5 MASK  6 DONE (W1C)  7 reads 0
//
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data; only the low WIDTH/CNT_W bits are used
//   readdata   : registered read data, one cycle latency
//   irq        : |(done & irq_mask)
//   out_port   : data ^ active
module pulse_out_pio #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 16,
  parameter int RESET_VALUE = 0,
  parameter int DEFAULT_LEN = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] done;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] trig;
  logic [WIDTH-1:0] done_set;
  logic [WIDTH-1:0] wd;
  logic [CNT_W-1:0] wd_len;
  logic [31:0]      rd_mux;
  logic             wr;

  // Upper writedata bits are ignored by design.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr     = chipselect & ~write_n;
  assign wd     = writedata[WIDTH-1:0];
  assign wd_len = writedata[CNT_W-1:0];

  always_comb begin
    active   = '0;
    trig     = '0;
    done_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      active[i] = (cnt[i] != '0);
      trig[i]   = wr && (address == 3'd3) && wd[i];
      // A retrigger on the final cycle reloads the counter, so the
      // interrupted pulse never reports completion.
      done_set[i] = (cnt[i] == CNT_W'(1)) && !trig[i];
    end
  end

  assign out_port = data ^ active;
  assign irq      = |(done & irq_mask);

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0, 3'd1, 3'd2: rd_mux[WIDTH-1:0] = data;
      3'd3:             rd_mux[WIDTH-1:0] = active;
      3'd4:             rd_mux[CNT_W-1:0] = len;
      3'd5:             rd_mux[WIDTH-1:0] = irq_mask;
      3'd6:             rd_mux[WIDTH-1:0] = done;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= WIDTH'(RESET_VALUE);
      len      <= CNT_W'(DEFAULT_LEN);
      irq_mask <= '0;
      done     <= '0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      if (wr) begin
        case (address)
          3'd0: data     <= wd;
          3'd1: data     <= data | wd;
          3'd2: data     <= data & ~wd;
          3'd4: len      <= (wd_len == '0) ? CNT_W'(1) : wd_len;
          3'd5: irq_mask <= wd;
          default: ;
        endcase
      end
      // Set takes priority over a same-cycle W1C.
      done <= (done & ~((wr && address == 3'd6) ? wd : '0)) | done_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (trig[i])
          cnt[i] <= len;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_out_pio.sv
// tb/tb_pulse_out_pio.sv - directed self-checking bench for pulse_out_pio
module tb_pulse_out_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  pulse_out_pio #(
    .WIDTH(4), .CNT_W(16), .RESET_VALUE(5), .DEFAULT_LEN(50)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the capturing posedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    // 1: reset
    repeat (2) @(negedge clk);
    check("rst_out", out_port, 32'h5);
    check("rst_irq", irq, 32'h0);
    check("rst_rd", readdata, 32'h0);
    reset_n = 1'b1;
    bus_read(3'd4, rd); check("len_default", rd, 32'd50);
    bus_read(3'd0, rd); check("data_reset", rd, 32'h5);
    bus_read(3'd5, rd); check("mask_reset", rd, 32'h0);
    check("out_after_rst", out_port, 32'h5);

    // 2: data / set / clr, upper bits ignored
    bus_write(3'd0, 32'hFFFF_FFF0);
    check("data_upper", out_port, 32'h0);
    bus_write(3'd1, 32'hA);
    bus_write(3'd2, 32'h2);
    check("setclr_out", out_port, 32'h8);
    bus_read(3'd0, rd); check("rd_data", rd, 32'h8);
    bus_read(3'd2, rd); check("rd_clr_alias", rd, 32'h8);
    bus_read(3'd7, rd); check("rd_reg7", rd, 32'h0);

    // 3: single pulse, done, irq, W1C
    bus_write(3'd0, 32'h0);
    bus_write(3'd4, 32'd3);
    bus_write(3'd5, 32'h1);
    bus_write(3'd3, 32'h1);                        // now in T+1
    check("p3_t1", out_port, 32'h1);
    @(negedge clk); check("p3_t2", out_port, 32'h1);
    @(negedge clk); check("p3_t3", out_port, 32'h1);
    check("p3_irq_t3", irq, 32'h0);
    @(negedge clk); check("p3_t4", out_port, 32'h0);
    check("p3_irq_t4", irq, 32'h1);
    bus_read(3'd6, rd); check("p3_done", rd, 32'h1);
    bus_write(3'd6, 32'h1);
    check("p3_irq_clr", irq, 32'h0);

    // 4: retrigger at T+2 with LEN=4
    bus_write(3'd4, 32'd4);
    bus_write(3'd3, 32'h1);                        // T+1
    check("p4_t1", out_port, 32'h1);
    @(negedge clk);                                // T+2: retrigger
    address = 3'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    check("p4_t2", out_port, 32'h1);
    @(negedge clk);                                // T+3
    chipselect = 1'b0; write_n = 1'b1;
    check("p4_t3", out_port, 32'h1);
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("p4_t%0d", k), out_port, 32'h1);
      check($sformatf("p4_irq_t%0d", k), irq, 32'h0);
    end
    @(negedge clk);                                // T+7
    check("p4_t7", out_port, 32'h0);
    check("p4_irq_t7", irq, 32'h1);
    bus_write(3'd6, 32'h1);
    check("p4_irq_clr", irq, 32'h0);

    // 5: LEN=0 stores 1; all-bit one-cycle pulse
    bus_write(3'd4, 32'd0);
    bus_read(3'd4, rd); check("len_zero", rd, 32'd1);
    bus_write(3'd3, 32'hF);
    check("p5_t1", out_port, 32'hF);
    @(negedge clk);
    check("p5_t2", out_port, 32'h0);
    bus_read(3'd6, rd); check("p5_done", rd, 32'hF);
    bus_write(3'd6, 32'hF);
    bus_read(3'd6, rd); check("p5_done_clr", rd, 32'h0);

    // 6a: W1C colliding with done set -> set wins
    bus_write(3'd4, 32'd2);
    bus_write(3'd3, 32'h1);                        // T+1
    @(negedge clk);                                // T+2: last active cycle
    address = 3'd6; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(3'd6, rd); check("collide_done", rd, 32'h1);
    check("collide_irq", irq, 32'h1);

    // 6b: reset mid-pulse
    bus_write(3'd0, 32'h3);
    bus_write(3'd4, 32'd10);
    bus_write(3'd3, 32'hF);
    @(negedge clk);
    check("mid_pulse_out", out_port, 32'hC);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", out_port, 32'h5);
    check("async_rst_irq", irq, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd6, rd); check("rst_done", rd, 32'h0);
    bus_read(3'd3, rd); check("rst_active", rd, 32'h0);
    repeat (12) @(negedge clk);
    bus_read(3'd6, rd); check("rst_no_late_done", rd, 32'h0);
    check("rst_out_final", out_port, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
